dm_banked_ws: RTL and testbench

- Parametrised successor to the single-cycle data memory in the CPU datapath.
- Adds:
  - byte/half/word loads and stores with sign or zero extension
  - little-endian byte lanes
  - misalignment detection
  - a configurable wait-state req/ready handshake, so the multicycle and pipelined cores can model slow memory
- Sits between the MEM stage / memory-control FSM and the architectural data store.

---
 rtl/dm_banked_ws.sv | 175 +++++++++++++++++
 tb/tb_dm_banked_ws.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dm_banked_ws.sv
// Byte-addressable data memory with little-endian sub-word access, misalignment
// flagging and a fixed wait-state req/ready handshake for slow-memory modelling.
module dm_banked_ws #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 0,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    // state | meaning
    // IDLE  | waiting for req; request fields are taken straight from the ports
    // WAIT  | legal access accepted, counting down wait states
    // DONE  | ready pulse; rdata/err already hold the result
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [31:0]      mem [DEPTH_WORDS] = '{default: '0};

    logic [1:0]       state;
    logic [3:0]       cnt;
    logic             we_q;
    logic [1:0]       size_q;
    logic             sign_q;
    logic [IDX_W+1:0] addr_q;
    logic [31:0]      wdata_q;

    logic             in_idle;
    logic             c_we;
    logic [1:0]       c_size;
    logic             c_sign;
    logic [IDX_W+1:0] c_addr;
    logic [31:0]      c_wdata;
    logic             legal;
    logic             do_access;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rd_word;
    logic [31:0]      shifted;
    logic [31:0]      load_val;
    logic [3:0]       wbe;
    logic [31:0]      wval;
    logic             unused_addr_hi;

    assign unused_addr_hi = ^addr[31:IDX_W+2];

    // In IDLE the access may complete at the accept edge, so use the live ports.
    assign in_idle = (state == ST_IDLE);
    assign c_we    = in_idle ? we                  : we_q;
    assign c_size  = in_idle ? size                : size_q;
    assign c_sign  = in_idle ? sign_ext            : sign_q;
    assign c_addr  = in_idle ? addr[IDX_W+1:0]     : addr_q;
    assign c_wdata = in_idle ? wdata               : wdata_q;

    always_comb begin
        legal = 1'b0;
        case (c_size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~c_addr[0];
            2'b10:   legal = (c_addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    assign do_access = (in_idle && req && legal && (WAIT_CYCLES == 0)) ||
                       ((state == ST_WAIT) && (cnt == 4'd0));

    assign idx     = c_addr[IDX_W+1:2];
    assign rd_word = mem[idx];
    assign shifted = rd_word >> {c_addr[1:0], 3'b000};

    always_comb begin
        load_val = '0;
        case (c_size)
            2'b00:   load_val = c_sign ? {{24{shifted[7]}}, shifted[7:0]}
                                       : {24'd0, shifted[7:0]};
            2'b01:   load_val = c_sign ? {{16{shifted[15]}}, shifted[15:0]}
                                       : {16'd0, shifted[15:0]};
            2'b10:   load_val = rd_word;
            default: load_val = '0;
        endcase
    end

    always_comb begin
        wbe  = 4'b0000;
        wval = c_wdata;
        case (c_size)
            2'b00: begin
                wbe  = 4'b0001 << c_addr[1:0];
                wval = {4{c_wdata[7:0]}};
            end
            2'b01: begin
                wbe  = c_addr[1] ? 4'b1100 : 4'b0011;
                wval = {2{c_wdata[15:0]}};
            end
            2'b10:   wbe = 4'b1111;
            default: wbe = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            rdata   <= '0;
            err     <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        sign_q  <= sign_ext;
                        addr_q  <= addr[IDX_W+1:0];
                        wdata_q <= wdata;
                        if (!legal) begin
                            state <= ST_DONE;
                            err   <= 1'b1;
                            rdata <= '0;
                        end else if (WAIT_CYCLES == 0) begin
                            state <= ST_DONE;
                            err   <= 1'b0;
                            rdata <= we ? 32'd0 : load_val;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ST_DONE;
                        err   <= 1'b0;
                        rdata <= we_q ? 32'd0 : load_val;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The array has no reset: contents survive rst_n.
    always_ff @(posedge clk) begin
        if (do_access && c_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe[i]) mem[idx][8*i +: 8] <= wval[8*i +: 8];
            end
        end
    end

    assign ready = (state == ST_DONE);
    assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_dm_banked_ws.sv
// Directed bench: one instance with no wait states, one with three wait states.
module tb_dm_banked_ws;

    logic        clk = 1'b0;
    logic        rst_n_0, req_0, we_0, sign_0;
    logic [1:0]  size_0;
    logic [31:0] addr_0, wdata_0, rdata_0;
    logic        ready_0, err_0, busy_0;
    logic        rst_n_3, req_3, we_3, sign_3;
    logic [1:0]  size_3;
    logic [31:0] addr_3, wdata_3, rdata_3;
    logic        ready_3, err_3, busy_3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_banked_ws #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n_0), .req(req_0), .we(we_0), .size(size_0),
        .sign_ext(sign_0), .addr(addr_0), .wdata(wdata_0), .rdata(rdata_0),
        .ready(ready_0), .err(err_0), .busy(busy_0)
    );

    dm_banked_ws #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n_3), .req(req_3), .we(we_3), .size(size_3),
        .sign_ext(sign_3), .addr(addr_3), .wdata(wdata_3), .rdata(rdata_3),
        .ready(ready_3), .err(err_3), .busy(busy_3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one request; lat = negedges after the accept edge until ready (0 = timeout).
    task automatic acc(input int w, input logic st, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic er);
        lat = 0;
        rd  = 'x;
        er  = 1'bx;
        @(negedge clk);
        if (w == 0) begin
            req_0 = 1'b1; we_0 = st; size_0 = sz; sign_0 = sx; addr_0 = a; wdata_0 = d;
        end else begin
            req_3 = 1'b1; we_3 = st; size_3 = sz; sign_3 = sx; addr_3 = a; wdata_3 = d;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            req_0 = 1'b0;
            req_3 = 1'b0;
            if ((w == 0) ? ready_0 : ready_3) begin
                lat = k;
                rd  = (w == 0) ? rdata_0 : rdata_3;
                er  = (w == 0) ? err_0 : err_3;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          first, second, nrdy, nbusy;

        rst_n_0 = 1'b0; req_0 = 1'b0; we_0 = 1'b0; size_0 = 2'b00; sign_0 = 1'b0;
        addr_0 = '0; wdata_0 = '0;
        rst_n_3 = 1'b0; req_3 = 1'b0; we_3 = 1'b0; size_3 = 2'b00; sign_3 = 1'b0;
        addr_3 = '0; wdata_3 = '0;
        #1;
        chk("rst_rdata0", rdata_0, 32'h0);
        chk("rst_ready0", {31'd0, ready_0}, 32'd0);
        chk("rst_err0",   {31'd0, err_0},   32'd0);
        chk("rst_busy0",  {31'd0, busy_0},  32'd0);
        chk("rst_busy3",  {31'd0, busy_3},  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n_0 = 1'b1;
        rst_n_3 = 1'b1;

        // ---- no wait states ----
        acc(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er);
        chk("sw_lat", lat, 1);
        chk("sw_err", {31'd0, er}, 32'd0);
        chk("sw_rdata", rd, 32'h0);
        acc(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
        chk("lw_lat", lat, 1);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", {31'd0, er}, 32'd0);
        @(negedge clk);
        chk("rdata_hold", rdata_0, 32'hDEADBEEF);
        chk("ready_drop", {31'd0, ready_0}, 32'd0);

        acc(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hAABBCC55, lat, rd, er);
        acc(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
        chk("sb_lw", rd, 32'hDEAD55EF);
        acc(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, er);
        chk("lb_sext", rd, 32'hFFFFFFDE);
        acc(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, er);
        chk("lbu", rd, 32'h000000DE);
        acc(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rd, er);
        chk("lhu", rd, 32'h0000DEAD);
        acc(0, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, rd, er);
        chk("lh_pos", rd, 32'h000055EF);
        acc(0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, lat, rd, er);
        acc(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, er);
        chk("sh_lh_neg", rd, 32'hFFFFBEEF);
        acc(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
        chk("sh_lw", rd, 32'hBEEF55EF);

        acc(0, 1'b1, 2'b10, 1'b0, 32'h400, 32'hA5A5A5A5, lat, rd, er);
        acc(0, 1'b0, 2'b10, 1'b0, 32'h000, 32'h0, lat, rd, er);
        chk("wrap_lw", rd, 32'hA5A5A5A5);

        // ---- three wait states ----
        acc(3, 1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344, lat, rd, er);
        chk("w3_sw_lat", lat, 4);
        acc(3, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, lat, rd, er);
        chk("w3_lw_lat", lat, 4);
        chk("w3_lw_rdata", rd, 32'h11223344);

        acc(3, 1'b1, 2'b10, 1'b0, 32'h06, 32'hFFFFFFFF, lat, rd, er);
        chk("mis_sw_lat", lat, 1);
        chk("mis_sw_err", {31'd0, er}, 32'd1);
        acc(3, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, lat, rd, er);
        chk("word1_kept", rd, 32'h0);
        chk("word1_err", {31'd0, er}, 32'd0);
        acc(3, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, lat, rd, er);
        acc(3, 1'b0, 2'b01, 1'b1, 32'h03, 32'h0, lat, rd, er);
        chk("mis_lh_lat", lat, 1);
        chk("mis_lh_err", {31'd0, er}, 32'd1);
        chk("mis_lh_rdata", rd, 32'h0);
        acc(3, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, lat, rd, er);
        chk("size11_err", {31'd0, er}, 32'd1);
        chk("size11_lat", lat, 1);

        // Reset one cycle into WAIT with err still set from the illegal access.
        @(negedge clk);
        req_3 = 1'b1; we_3 = 1'b1; size_3 = 2'b10; addr_3 = 32'h20; wdata_3 = 32'h12345678;
        @(negedge clk);
        req_3 = 1'b0;
        chk("pre_rst_busy", {31'd0, busy_3}, 32'd1);
        @(negedge clk);
        rst_n_3 = 1'b0;
        #1;
        chk("mid_rst_busy",  {31'd0, busy_3},  32'd0);
        chk("mid_rst_ready", {31'd0, ready_3}, 32'd0);
        chk("mid_rst_err",   {31'd0, err_3},   32'd0);
        chk("mid_rst_rdata", rdata_3, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n_3 = 1'b1;
        acc(3, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, er);
        chk("rst_discard", rd, 32'h0);
        chk("rst_lw_lat", lat, 4);

        // req pulses during WAIT must not start a second access.
        @(negedge clk);
        req_3 = 1'b1; we_3 = 1'b0; size_3 = 2'b10; addr_3 = 32'h08;
        nrdy = 0;
        nbusy = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ready_3) nrdy++;
            if (busy_3) nbusy++;
            req_3 = (k <= 3);
        end
        chk("pulse_readys", nrdy, 1);
        chk("busy_cycles", nbusy, 4);

        // req held high: consecutive ready pulses are WAIT_CYCLES+2 apart.
        @(negedge clk);
        req_3 = 1'b1; we_3 = 1'b0; size_3 = 2'b10; addr_3 = 32'h08;
        first = 0;
        second = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (ready_3) begin
                if (first == 0) first = k;
                else second = k;
            end
            if (k == 9) req_3 = 1'b0;
        end
        chk("held_first", first, 4);
        chk("held_spacing", second - first, 5);
        chk("held_rdata", rdata_3, 32'h11223344);

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
